// File: rtl/washer_ctrl_timed.sv
// Wash-machine sequencer with an internal phase down-counter, configurable rinse
// passes, heavy wash, door pause/resume and abort-to-drain.
module washer_ctrl_timed #(
  parameter int FILL_CYC  = 4,
  parameter int WASH_CYC  = 8,
  parameter int DRAIN_CYC = 3,
  parameter int RINSE_CYC = 6,
  parameter int SPIN_CYC  = 5,
  parameter int MAX_RINSE = 3,
  parameter int CNT_W     = 16,
  parameter int RW        = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          door,
  input  logic          abort,
  input  logic          heavy,
  input  logic [RW-1:0] num_rinse,
  output logic          water,
  output logic          agitator,
  output logic          pump,
  output logic          motor,
  output logic          spin_fast,
  output logic          busy,
  output logic          paused,
  output logic          done,
  output logic [2:0]    state,
  output logic [RW-1:0] rinse_left
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL1  = 3'd1,
    S_WASH   = 3'd2,
    S_DRAIN1 = 3'd3,
    S_FILL2  = 3'd4,
    S_RINSE  = 3'd5,
    S_DRAIN2 = 3'd6,
    S_SPIN   = 3'd7
  } state_t;

  localparam logic [RW-1:0] MAXR = RW'(MAX_RINSE);

  state_t           st;
  logic [CNT_W-1:0] tmr;
  logic [RW-1:0]    rleft;
  logic             hvy;
  logic             abt;
  logic             done_r;

  function automatic logic [RW-1:0] clamp_rinse(input logic [RW-1:0] n);
    return (n > MAXR) ? MAXR : n;
  endfunction

  // Timer load value is the phase length minus one so a phase lasts *_CYC cycles.
  function automatic logic [CNT_W-1:0] load_val(input state_t s, input logic hv);
    case (s)
      S_FILL1, S_FILL2:  load_val = CNT_W'(FILL_CYC - 1);
      S_WASH:            load_val = hv ? CNT_W'(2 * WASH_CYC - 1) : CNT_W'(WASH_CYC - 1);
      S_DRAIN1, S_DRAIN2: load_val = CNT_W'(DRAIN_CYC - 1);
      S_RINSE:           load_val = CNT_W'(RINSE_CYC - 1);
      S_SPIN:            load_val = CNT_W'(SPIN_CYC - 1);
      default:           load_val = '0;
    endcase
  endfunction

  assign busy       = (st != S_IDLE);
  assign paused     = busy & door;
  assign state      = st;
  assign done       = done_r;
  assign rinse_left = rleft;

  assign water     = !paused && (st == S_FILL1 || st == S_FILL2);
  assign agitator  = !paused && (st == S_WASH || st == S_RINSE);
  assign pump      = !paused && (st == S_DRAIN1 || st == S_DRAIN2 || st == S_SPIN);
  assign motor     = !paused && (st == S_SPIN);
  assign spin_fast = !paused && (st == S_SPIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= S_IDLE;
      tmr    <= '0;
      rleft  <= '0;
      hvy    <= 1'b0;
      abt    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (st == S_IDLE) begin
        if (start && !door) begin
          st    <= S_FILL1;
          tmr   <= load_val(S_FILL1, heavy);
          rleft <= clamp_rinse(num_rinse);
          hvy   <= heavy;
          abt   <= 1'b0;
        end
      end else if (!door) begin
        if (abort && st != S_DRAIN2 && st != S_SPIN) begin
          st    <= S_DRAIN2;
          tmr   <= load_val(S_DRAIN2, hvy);
          rleft <= '0;
          abt   <= 1'b1;
        end else if (abort && st == S_SPIN) begin
          st     <= S_IDLE;
          done_r <= 1'b1;
        end else begin
          // Only DRAIN2 reaches here with abort high: finish this drain, then stop.
          if (abort) begin
            abt   <= 1'b1;
            rleft <= '0;
          end
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            case (st)
              S_FILL1: begin st <= S_WASH;   tmr <= load_val(S_WASH, hvy);   end
              S_WASH:  begin st <= S_DRAIN1; tmr <= load_val(S_DRAIN1, hvy); end
              S_DRAIN1: begin
                if (rleft != '0) begin
                  st  <= S_FILL2;
                  tmr <= load_val(S_FILL2, hvy);
                end else begin
                  st  <= S_SPIN;
                  tmr <= load_val(S_SPIN, hvy);
                end
              end
              S_FILL2: begin st <= S_RINSE;  tmr <= load_val(S_RINSE, hvy);  end
              S_RINSE: begin st <= S_DRAIN2; tmr <= load_val(S_DRAIN2, hvy); end
              S_DRAIN2: begin
                if (abt || abort) begin
                  st     <= S_IDLE;
                  done_r <= 1'b1;
                end else if (rleft > RW'(1)) begin
                  st    <= S_FILL2;
                  tmr   <= load_val(S_FILL2, hvy);
                  rleft <= rleft - 1'b1;
                end else begin
                  st    <= S_SPIN;
                  tmr   <= load_val(S_SPIN, hvy);
                  rleft <= '0;
                end
              end
              S_SPIN: begin
                st     <= S_IDLE;
                done_r <= 1'b1;
              end
              default: st <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_washer_ctrl_timed.sv
// Bench for washer_ctrl_timed: phase-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized panel activity.
module tb_washer_ctrl_timed;

  localparam int F = 4, W = 8, D = 3, R = 6, S = 5, MAXR = 3;

  logic       clk, reset_n, start, door, abort, heavy;
  logic [1:0] num_rinse;
  logic       water, agitator, pump, motor, spin_fast, busy, paused, done;
  logic [2:0] state;
  logic [1:0] rinse_left;
  logic [12:0] o2;

  washer_ctrl_timed dut (
    .clk(clk), .reset_n(reset_n), .start(start), .door(door), .abort(abort),
    .heavy(heavy), .num_rinse(num_rinse), .water(water), .agitator(agitator),
    .pump(pump), .motor(motor), .spin_fast(spin_fast), .busy(busy),
    .paused(paused), .done(done), .state(state), .rinse_left(rinse_left)
  );

  washer_ctrl_timed #(.MAX_RINSE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .door(door), .abort(abort),
    .heavy(heavy), .num_rinse(num_rinse), .water(o2[7]), .agitator(o2[6]),
    .pump(o2[5]), .motor(o2[4]), .spin_fast(o2[3]), .busy(o2[10]),
    .paused(o2[9]), .done(o2[8]), .state(o2[12:11]), .rinse_left(o2[1:0])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] st;
    int         len;
    logic [1:0] rl;
  } ph_t;

  ph_t q[$];
  bit  m_abt, m_done;

  int n_tests = 0, n_fail = 0;
  int busy_cnt, water_cnt, motor_cnt, done_cnt, spin_seen, b2_cnt, rl2_max;
  logic [29:0] seq;
  logic [5:0]  rl_seq;
  logic [2:0]  last_st;
  logic        last_busy;

  function automatic ph_t mk(input int st, input int len, input int rl);
    ph_t p;
    p.st = 3'(st); p.len = len; p.rl = 2'(rl);
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_abt = 0;
    m_done = 0;
  endtask

  task automatic build(input int r, input bit h);
    q.delete();
    q.push_back(mk(1, F, r));
    q.push_back(mk(2, h ? 2 * W : W, r));
    q.push_back(mk(3, D, r));
    for (int i = r; i >= 1; i--) begin
      q.push_back(mk(4, F, i));
      q.push_back(mk(5, R, i));
      q.push_back(mk(6, D, i));
    end
    q.push_back(mk(7, S, 0));
    m_abt = 0;
  endtask

  task automatic model_step();
    bit  dn;
    ph_t h;
    int  r;
    dn = 0;
    if (q.size() == 0) begin
      if (start && !door) begin
        r = (num_rinse > MAXR) ? MAXR : int'(num_rinse);
        build(r, heavy);
      end
    end else if (!door) begin
      if (abort && q[0].st >= 1 && q[0].st <= 5) begin
        q.delete();
        q.push_back(mk(6, D, 0));
        m_abt = 1;
      end else if (abort && q[0].st == 7) begin
        q.delete();
        dn = 1;
      end else begin
        h = q[0];
        if (abort && h.st == 6 && !m_abt) begin
          m_abt = 1;
          h.rl = 0;
          q.delete();
          q.push_back(h);
        end
        h.len = h.len - 1;
        if (h.len == 0) begin
          void'(q.pop_front());
          if (q.size() == 0) dn = 1;
        end else begin
          q[0] = h;
        end
      end
    end
    m_done = dn;
  endtask

  function automatic logic [12:0] exp_vec();
    logic [2:0] s;
    logic [1:0] rl;
    logic b, p;
    s = 0; rl = 0; b = 0;
    if (q.size() != 0) begin
      b = 1; s = q[0].st; rl = q[0].rl;
    end
    p = b && door;
    return {s, b, p, m_done, !p && (s == 1 || s == 4), !p && (s == 2 || s == 5),
            !p && (s == 3 || s == 6 || s == 7), !p && s == 7, !p && s == 7, rl};
  endfunction

  function automatic logic [12:0] act_vec();
    return {state, busy, paused, done, water, agitator, pump, motor, spin_fast, rinse_left};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; water_cnt = 0; motor_cnt = 0; done_cnt = 0; spin_seen = 0;
    b2_cnt = 0; rl2_max = 0; seq = '0; rl_seq = '0; last_st = 3'd0;
  endtask

  task automatic tick();
    logic [12:0] a, e;
    @(negedge clk);
    a = act_vec();
    e = exp_vec();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle_compare t=%0t got %b expected %b", $time, a, e);
    end
    last_busy = busy;
    if (busy) busy_cnt++;
    if (water) water_cnt++;
    if (motor) motor_cnt++;
    if (done) done_cnt++;
    if (state == 3'd7) spin_seen = 1;
    if (state == 3'd5 && last_st != 3'd5) rl_seq = {rl_seq[3:0], rinse_left};
    if (state != last_st) begin
      seq = {seq[26:0], state};
      last_st = state;
    end
    if (o2[10]) b2_cnt++;
    if (int'(o2[1:0]) > rl2_max) rl2_max = int'(o2[1:0]);
    @(posedge clk);
    if (reset_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic run(input int r, input bit h, input int dfrom, input int dlen, input int ab_at);
    clear_stats();
    num_rinse = 2'(r); heavy = h; start = 1; door = 0; abort = 0;
    tick();
    start = 0;
    for (int i = 0; i < 300; i++) begin
      door  = (i >= dfrom && i < dfrom + dlen);
      abort = (i == ab_at);
      tick();
      if (!last_busy) break;
    end
    door = 0; abort = 0;
    check("run_returns_idle", longint'(last_busy), 0);
    tick();
  endtask

  initial begin
    reset_n = 0; start = 0; door = 0; abort = 0; heavy = 0; num_rinse = 0;
    o2[2] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", longint'(act_vec()), 0);
    reset_n = 1;

    // MAX_RINSE=2 instance clamps 3 to 2 passes; main instance runs all 3
    run(3, 0, 999, 0, -1);
    check("clamp_dut2_busy", b2_cnt, 46);
    check("clamp_dut2_rinse_max", rl2_max, 2);
    check("clamp_dut2_idle", longint'(o2), 0);
    check("r3_busy", busy_cnt, 59);

    run(1, 0, 999, 0, -1);
    check("r1_busy", busy_cnt, 33);
    check("r1_seq", seq, 30'o12345670);
    check("r1_done_once", done_cnt, 1);
    check("r1_water", water_cnt, 8);

    run(0, 0, 999, 0, -1);
    check("r0_busy", busy_cnt, 20);
    check("r0_seq", seq, 30'o12370);

    run(3, 1, 999, 0, -1);
    check("r3h_busy", busy_cnt, 67);
    check("r3h_rinse_left", rl_seq, 6'b111001);

    run(1, 0, 30, 10, -1);
    check("door_spin_busy", busy_cnt, 43);
    check("door_spin_motor", motor_cnt, 5);

    door = 1; start = 1; num_rinse = 1;
    repeat (3) tick();
    check("start_door_open", longint'(last_busy), 0);
    start = 0; door = 0;
    tick();

    run(1, 0, 999, 0, 6);
    check("abort_wash_busy", busy_cnt, 10);
    check("abort_wash_seq", seq, 30'o1260);
    check("abort_wash_nospin", spin_seen, 0);
    check("abort_wash_done", done_cnt, 1);

    run(0, 0, 999, 0, 16);
    check("abort_spin_busy", busy_cnt, 17);
    check("abort_spin_seq", seq, 30'o12370);

    run(1, 0, 999, 0, 18);
    check("abort_fill2_expiry_seq", seq, 30'o123460);
    check("abort_fill2_busy", busy_cnt, 22);

    // Asynchronous reset in the middle of RINSE
    clear_stats();
    num_rinse = 1; heavy = 0; start = 1;
    tick();
    start = 0;
    repeat (21) tick();
    check("pre_reset_rinse", longint'(state), 5);
    #2;
    reset_n = 0;
    #1;
    check("async_reset_outputs", longint'(act_vec()), 0);
    model_reset();
    repeat (2) tick();
    reset_n = 1;
    repeat (4) tick();
    check("reset_no_done", done_cnt, 0);

    for (int i = 0; i < 4000; i++) begin
      if (door) door = ($urandom_range(0, 4) != 0);
      else      door = ($urandom_range(0, 19) == 0);
      start     = ($urandom_range(0, 5) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      heavy     = 1'($urandom);
      num_rinse = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/washer_ctrl_timed.md
# washer_ctrl_timed

Parametrised wash-machine sequencer with on-chip phase timers. It replaces the externally timed washer FSM, which needed Tf/Tw/Td/Tr/Ts done inputs, with one internal down-counter. It adds a configurable rinse count, a heavy-wash mode, door pause/resume, and abort-to-drain. It sits between the front-panel inputs and the actuator drivers.

## Interface
- FILL_CYC, default 4: cycles spent in each fill phase.
- WASH_CYC, default 8: cycles in WASH; doubled when heavy mode is latched.
- DRAIN_CYC, default 3: cycles in each drain phase.
- RINSE_CYC, default 6: cycles in each RINSE phase.
- SPIN_CYC, default 5: cycles in SPIN.
- MAX_RINSE, default 3: largest accepted rinse count.
- CNT_W, default 16: timer width. It must hold 2*WASH_CYC-1 and every other *_CYC-1.
- RW, default 2: rinse-count width, clog2(MAX_RINSE+1).
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; requests a cycle; sampled in IDLE only.
- door  in  1  1 = door open.
- abort  in  1  level; requests an early drain-and-stop.
- heavy  in  1  heavy-wash select; latched when start is accepted.
- num_rinse  in  RW  rinse passes; latched when start is accepted. Values above MAX_RINSE are clamped to MAX_RINSE.
- water, agitator, pump, motor, spin_fast  out  1 each  actuator enables.
- busy  out  1  1 in every state except IDLE.
- paused  out  1  equals busy & door.
- done  out  1  registered one-cycle pulse when a cycle ends.
- state  out  3  current state encoding.
- rinse_left  out  RW  rinse passes still to run, including the current pass.

## Operation
- State encodings: IDLE=0, FILL1=1, WASH=2, DRAIN1=3, FILL2=4, RINSE=5, DRAIN2=6, SPIN=7.
- Reset value of every output is 0; state resets to IDLE. Reset applied mid-cycle aborts at once with no done pulse.
- Timer behaviour:
  - Entering a phase loads the timer with its duration minus 1.
  - The timer decrements on each edge where paused=0.
  - The phase exits on the edge where the timer is 0 and paused=0.
  - A phase therefore lasts exactly its *_CYC unpaused cycles.
- IDLE -> FILL1 when start=1 and door=0. start with door=1 is ignored.
- Normal transitions:
  - FILL1 -> WASH.
  - WASH -> DRAIN1.
  - DRAIN1 -> FILL2 if the latched num_rinse > 0, otherwise -> SPIN.
  - FILL2 -> RINSE.
  - RINSE -> DRAIN2.
  - DRAIN2 -> FILL2 if rinse_left > 1, decrementing rinse_left; otherwise -> SPIN.
  - SPIN -> IDLE with done=1 on the following cycle.
- rinse_left is loaded with num_rinse on start acceptance.
- Actuator decode is combinational from state, gated off while paused:
  - FILL1/FILL2: water.
  - WASH/RINSE: agitator.
  - DRAIN1/DRAIN2: pump.
  - SPIN: motor, spin_fast and pump.
  - IDLE: all actuators 0.
- Door pause: while paused=1, all actuators are 0, the timer holds and state holds. Closing the door resumes the same phase with the remaining count.
- Abort, in any of FILL1 through RINSE:
  - Next edge goes to DRAIN2 with rinse_left=0, timer loaded, and an internal abort flag set.
  - DRAIN2 with the abort flag set exits to IDLE, skipping SPIN, and pulses done.
- Abort in other states:
  - In SPIN: -> IDLE on the next edge, with done.
  - In an abort-DRAIN2 or in IDLE: ignored.
- Precedence:
  - abort beats timer expiry.
  - In IDLE, start beats abort.
  - A door open on the expiry cycle blocks the transition.

## Timing
- Start latency: start is sampled high at edge k, so state=FILL1 and water=1 after edge k.
- Busy length for R rinses, in unpaused cycles: FILL+WASH'+DRAIN + R*(FILL+RINSE+DRAIN) + SPIN, where WASH' is 2*WASH_CYC when heavy.
- done is high for exactly one cycle, the first cycle of IDLE after the cycle ends.
- A new start is accepted in that same cycle.
- Every cycle spent paused adds exactly one cycle to the busy length.

## Test plan
- Defaults, num_rinse=1, heavy=0, door=0: busy=1 for exactly 33 cycles; state sequence is 1,2,3,4,5,6,7; done pulses once; water is high for 4+4 cycles.
- num_rinse=0: DRAIN1 goes directly to SPIN; busy lasts 20 cycles. num_rinse=3 with heavy=1: busy lasts 4+16+3+39+5 = 67 cycles; rinse_left counts 3,2,1.
- door=1 for 10 cycles mid-SPIN: motor=0 and paused=1 throughout; the timer is frozen; total busy is 43 cycles. start while door=1 in IDLE: no start.
- abort on the 3rd WASH cycle: next state is DRAIN2 with pump=1 for 3 cycles, then IDLE with done=1 and SPIN never entered. abort in SPIN: IDLE on the next edge.
- abort together with timer expiry in FILL2: DRAIN2 is taken, not RINSE. num_rinse=3 when MAX_RINSE=2: clamped to 2 passes.
- reset_n pulled low mid-RINSE, asynchronously between edges: all outputs go to 0 immediately, state=0, and done stays 0.
